tape_mem: RTL
=============

Name: tape_mem

Overview:
- Data-tape responder for the brainfuck-style execution core.
- Serves the ALU's combinational cell read and absorbs its per-cycle writeback.
- The ALU latches `val_in` and `ptr` on the same edge, so reads are asynchronous, with write-to-read bypass for the same-cycle case.
- Owns a post-reset clear sequencer that zeroes every cell and holds `ready` low until the tape is clean; fetch stalls on `!ready`.

Parameters:
- DATA_W, 16, cell width; matches the ALU datapath.
- DEPTH, 1024, number of cells; must be a power of two, at least 2.
- ADDR_W, $clog2(DEPTH), derived; number of index bits actually decoded.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- ptr_select  input  16  cell index to read; the ALU's next pointer.
- ptr_wb  input  16  cell index to write; the ALU's current pointer.
- wb_val  input  DATA_W  writeback data; the ALU's `val_out`.
- wb_en  input  1  writeback strobe.
- val_out  output  DATA_W  cell value at `ptr_select`; feeds the ALU's `val_in`.
- ready  output  1  high once the clear sequence has finished.
- oob_err  output  1  sticky out-of-bounds flag; see Optional Feature.

Behaviour:
- Index decode: only `ptr[ADDR_W-1:0]` is used, so addresses wrap modulo DEPTH. Pointer 0xFFFF after a DEC from 0 aliases cell DEPTH-1.
- States: CLEAR, RUN. A 2-state FSM plus an ADDR_W-bit counter `clr_addr`.
- Reset (sampled at a rising edge with rst=1):
  - state <= CLEAR, clr_addr <= 0, ready <= 0, oob_err <= 0.
  - Memory contents are not reset directly; the CLEAR sweep zeroes them.
- CLEAR:
  - Each cycle: mem[clr_addr] <= 0 and clr_addr <= clr_addr+1.
  - When clr_addr == DEPTH-1, after that cell is written: state <= RUN, ready <= 1.
  - ready is therefore first seen high on the cycle after the DEPTH-th clear edge, i.e. DEPTH cycles after rst deasserts.
  - wb_en is ignored (write dropped). val_out is forced to 0.
- RUN:
  - On the edge, if wb_en=1: mem[ptr_wb] <= wb_val.
- val_out (combinational, RUN):
  - If wb_en=1 and the low ADDR_W bits of ptr_wb and ptr_select match: val_out = wb_val (bypass).
  - Otherwise: val_out = mem[ptr_select].
  - Latency from a write to an observable read is 0 cycles through the bypass, and 1 cycle via the array.
- Simultaneous events: one read and one write per cycle, no port conflict. rst has priority over everything.
- Reset mid-operation:
  - rst in RUN restarts CLEAR from cell 0; ready drops on the next edge.
  - rst in CLEAR restarts the sweep at 0.
- No X on val_out after reset, because every cell is written before ready=1.

Optional Feature:
- Macro: TAPE_BOUNDS_CHECK_EN.
- Defined:
  - In RUN, oob_err <= 1 on any edge where ptr_select >= DEPTH, or wb_en=1 with ptr_wb >= DEPTH (full 16-bit compare).
  - It is sticky until rst. Wrapping access still proceeds.
- Undefined: oob_err is tied 0 and no compare logic is built.

Decomposition:
- Package tape_pkg:
  - DATA_W default.
  - DEPTH default.
  - State enum {TAPE_CLEAR, TAPE_RUN}.
  - Function to truncate a 16-bit pointer to ADDR_W bits.
- Sub-module tape_ram:
  - DEPTH x DATA_W array.
  - One asynchronous read port and one synchronous write port, no reset.
  - The write port is muxed between the clear sequencer and the ALU writeback in tape_mem.
  - Bypass logic stays in tape_mem.

Test Plan:
- Reset clear, with DEPTH=16:
  - Preload the array with 0xAAAA and pulse rst for 1 cycle.
  - Required: ready low for exactly 16 cycles then high.
  - Required: every cell then reads 0x0000, and val_out=0 throughout CLEAR.
- Bypass:
  - In RUN, set ptr_select=ptr_wb=5, wb_val=0x0001, wb_en=1.
  - Required: val_out=0x0001 in the same cycle.
  - Required: after the edge, with wb_en=0, val_out=0x0001 from the array.
- No bypass on address mismatch:
  - Write 0x0007 to cell 3, then set ptr_select=4, ptr_wb=3, wb_en=1, wb_val=0x0009.
  - Required: val_out=0x0000. Next cycle, ptr_select=3 gives 0x0009.
- Wrap:
  - With DEPTH=16, write 0x1234 at ptr_wb=0xFFFF.
  - Required: ptr_select=15 reads 0x1234.
  - Required: with TAPE_BOUNDS_CHECK_EN defined oob_err=1; undefined oob_err=0.
- Write during CLEAR:
  - Assert wb_en with ptr_wb=2, wb_val=0x00FF while ready=0.
  - Required: after ready rises, cell 2 reads 0x0000.
- Mid-run reset:
  - Write 0x0055 to cell 7, then assert rst for 1 cycle.
  - Required: ready=0 on the next cycle, and after the sweep cell 7 reads 0x0000.

Source files
------------

// File: rtl/tape_pkg.sv
// Shared types and defaults for the data tape: cell geometry, sequencer states, pointer decode.
// No logic or latency of its own; imported by tape_mem and tape_ram.
// No flow control here; the bounds-check option (TAPE_BOUNDS_CHECK_EN) is resolved in tape_mem.
package tape_pkg;

    localparam int TAPE_DATA_W = 16;
    localparam int TAPE_DEPTH  = 1024;
    localparam int PTR_W       = 16;

    typedef enum logic {
        TAPE_CLEAR = 1'b0,
        TAPE_RUN   = 1'b1
    } tape_state_t;

    // Keeps only the decoded index bits, so out-of-range pointers alias modulo the depth.
    function automatic logic [PTR_W-1:0] ptr_wrap(input logic [PTR_W-1:0] ptr, input int addr_w);
        logic [PTR_W-1:0] mask;
        mask = (PTR_W'(1) << addr_w) - PTR_W'(1);
        return ptr & mask;
    endfunction

endpackage

// File: rtl/tape_ram.sv
// Tape cell array: one asynchronous read port, one synchronous write port, contents not reset.
// Read latency 0 (combinational); a write is visible through this port from the next cycle.
// No backpressure: one read and one write accepted every cycle.
module tape_ram
    import tape_pkg::*;
#(
    parameter int DATA_W = TAPE_DATA_W,
    parameter int DEPTH  = TAPE_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/tape_mem.sv
// Data tape for the execution core: async cell read with same-cycle write bypass, post-reset clear sweep.
// Read latency 0; ready rises DEPTH cycles after reset releases. Optional sticky oob_err via TAPE_BOUNDS_CHECK_EN.
// No backpressure: writes during the clear sweep are dropped and val_out reads 0 until ready.
module tape_mem
    import tape_pkg::*;
#(
    parameter int DATA_W = TAPE_DATA_W,
    parameter int DEPTH  = TAPE_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       ptr_select,
    input  logic [15:0]       ptr_wb,
    input  logic [DATA_W-1:0] wb_val,
    input  logic              wb_en,
    output logic [DATA_W-1:0] val_out,
    output logic              ready,
    output logic              oob_err
);

    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - 1);

    tape_state_t       state;
    logic [ADDR_W-1:0] clr_addr;

    logic [ADDR_W-1:0] sel_idx;
    logic [ADDR_W-1:0] wb_idx;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    assign sel_idx = ADDR_W'(ptr_wrap(ptr_select, ADDR_W));
    assign wb_idx  = ADDR_W'(ptr_wrap(ptr_wb, ADDR_W));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= TAPE_CLEAR;
            clr_addr <= '0;
            ready    <= 1'b0;
        end else begin
            case (state)
                TAPE_CLEAR: begin
                    clr_addr <= clr_addr + ADDR_W'(1);
                    if (clr_addr == CLR_LAST) begin
                        state <= TAPE_RUN;
                        ready <= 1'b1;
                    end
                end
                default: begin
                    state <= TAPE_RUN;
                end
            endcase
        end
    end

    // The clear sweep owns the write port; ALU writebacks are dropped until it finishes.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = wb_idx;
        ram_wdata = wb_val;
        if (!rst) begin
            if (state == TAPE_CLEAR) begin
                ram_we    = 1'b1;
                ram_waddr = clr_addr;
                ram_wdata = '0;
            end else begin
                ram_we    = wb_en;
            end
        end
    end

    tape_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (sel_idx),
        .rdata (ram_rdata)
    );

    // Bypass covers the ALU reading the cell it is writing back in the same cycle.
    always_comb begin
        val_out = '0;
        if (state == TAPE_RUN) begin
            if (wb_en && (wb_idx == sel_idx)) begin
                val_out = wb_val;
            end else begin
                val_out = ram_rdata;
            end
        end
    end

`ifdef TAPE_BOUNDS_CHECK_EN
    localparam logic [16:0] DEPTH_X = 17'(DEPTH);

    always_ff @(posedge clk) begin
        if (rst) begin
            oob_err <= 1'b0;
        end else if (state == TAPE_RUN &&
                     (({1'b0, ptr_select} >= DEPTH_X) ||
                      (wb_en && ({1'b0, ptr_wb} >= DEPTH_X)))) begin
            oob_err <= 1'b1;
        end
    end
`else
    assign oob_err = 1'b0;
`endif

endmodule
